// File: rtl/rvfi_bmc_env_ctrl.sv
// rvfi_bmc_env_ctrl: environment controller for RVFI formal/BMC benches.
//   Drives the core reset release, the checker enable at a configurable depth
//   (pulse or level), per-channel memory stall watchdogs, and an env_ok qualifier.
// Ports:
//   clk, reset (sync, active-high), trap, mem_valid[NCH], mem_ready[NCH]
//   core_resetn, check_enable, cycle[CW], wait_cnt[NCH*WW], wait_violation[NCH], env_ok
// Optional: define RISCV_FORMAL_TRAP_STOP_EN to make a trap end the environment
//   (env_ok forced low, level-mode check_enable dropped). Default build ignores trap.
module rvfi_bmc_env_ctrl #(
  parameter int NCH          = 1,
  parameter int CW           = 8,
  parameter int DEPTH        = 20,
  parameter int RESET_CYCLES = 1,
  parameter int CHECK_MODE   = 0,
  parameter int MAX_WAIT     = 4,
  parameter int WW           = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trap,
  input  logic [NCH-1:0]    mem_valid,
  input  logic [NCH-1:0]    mem_ready,
  output logic              core_resetn,
  output logic              check_enable,
  output logic [CW-1:0]     cycle,
  output logic [NCH*WW-1:0] wait_cnt,
  output logic [NCH-1:0]    wait_violation,
  output logic              env_ok
);

  localparam logic [CW-1:0] CYC_MAX  = '1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = '1;
  localparam logic [WW-1:0] MW_C     = WW'(MAX_WAIT);

  logic rel_now;       // cycle has reached the reset-release point
  logic at_depth;
  logic ce_nxt;
  logic trap_stop;     // environment terminated by a trap

  // With a single reset cycle the release condition is unconditionally true;
  // splitting it out avoids an always-true unsigned compare.
  generate
    if (RESET_CYCLES <= 1) begin : g_rel_imm
      assign rel_now = 1'b1;
    end else begin : g_rel_cmp
      assign rel_now = (cycle >= CW'(RESET_CYCLES - 1));
    end
  endgenerate

  assign at_depth = (cycle == DEPTH_C);

`ifdef RISCV_FORMAL_TRAP_STOP_EN
  logic trap_seen;

  // Traps are only meaningful once the core is out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_seen <= 1'b0;
    end else if (trap && core_resetn) begin
      trap_seen <= 1'b1;
    end
  end

  assign trap_stop = trap_seen;
`else
  logic unused_trap;
  assign unused_trap = trap;
  assign trap_stop   = 1'b0;
`endif

  // Pulse mode re-derives the enable from the compare each cycle, so it only
  // fires once: cycle saturates above DEPTH and never equals it again.
  // Level mode latches the compare and is cleared only by a trap stop.
  generate
    if (CHECK_MODE == 0) begin : g_ce_pulse
      assign ce_nxt = at_depth;
    end else begin : g_ce_level
      assign ce_nxt = (check_enable | at_depth) & ~trap_stop;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle        <= '0;
      core_resetn  <= 1'b0;
      check_enable <= 1'b0;
    end else begin
      if (cycle != CYC_MAX) begin
        cycle <= cycle + CW'(1);
      end
      if (rel_now) begin
        core_resetn <= 1'b1;
      end
      check_enable <= ce_nxt;
    end
  end

  // Per-channel stall watchdog. A stall observed while the counter already
  // holds MAX_WAIT is the first stall beyond the permitted bound.
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [WW-1:0] cnt_q;
      logic          viol_q;
      logic          stall;

      assign stall = mem_valid[i] & ~mem_ready[i];

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= '0;
          viol_q <= 1'b0;
        end else if (!core_resetn) begin
          cnt_q <= '0;
        end else if (stall) begin
          if (cnt_q != WAIT_MAX) begin
            cnt_q <= cnt_q + WW'(1);
          end
          if (cnt_q >= MW_C) begin
            viol_q <= 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign wait_cnt[i*WW +: WW] = cnt_q;
      assign wait_violation[i]    = viol_q;
    end
  endgenerate

  assign env_ok = ~(|wait_violation) & ~trap_stop;

endmodule
